// File: rtl/GAM_package.sv
// Shared constants and types for the GAM datapath.
package GAM_package;

  localparam int unsigned VECTOR_LEN = 16;
  localparam int unsigned ELEM_W     = 8;

  // Width of the squared-distance sum; wide enough that it can never overflow.
  localparam int unsigned ED_SUM_W = 2 * ELEM_W + $clog2(VECTOR_LEN);

  typedef logic [VECTOR_LEN*ELEM_W-1:0] node_vector_T;

endpackage

// File: rtl/ed_sq_diff.sv
// One element lane: registered |x - w|, then registered square of that difference.
module ed_sq_diff
  import GAM_package::*;
#(
  parameter int unsigned ELEM_W = GAM_package::ELEM_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ld_diff_i,
  input  logic                  ld_sq_i,
  input  logic [ELEM_W-1:0]     x_e_i,
  input  logic [ELEM_W-1:0]     w_e_i,
  output logic [2*ELEM_W-1:0]   sq_o
);

  logic [ELEM_W-1:0]   diff_d, diff_q;
  logic [2*ELEM_W-1:0] sq_d, sq_q;

  // Next-state: each register loads only when its stage's incoming valid is set.
  always_comb begin
    diff_d = diff_q;
    sq_d   = sq_q;
    if (ld_diff_i) begin
      diff_d = (x_e_i >= w_e_i) ? (x_e_i - w_e_i) : (w_e_i - x_e_i);
    end
    if (ld_sq_i) begin
      sq_d = (2*ELEM_W)'(diff_q) * (2*ELEM_W)'(diff_q);
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      diff_q <= '0;
      sq_q   <= '0;
    end else begin
      diff_q <= diff_d;
      sq_q   <= sq_d;
    end
  end

  assign sq_o = sq_q;

endmodule

// File: rtl/ed_calculator.sv
// Pipelined squared-Euclidean-distance engine: ED = sum_j (x_j - w_j)^2, latency 3.
// Optional feature macro ED_SQRT_EN: adds a fourth stage holding floor(sqrt(sum)),
// so ED becomes the true Euclidean distance with latency 4.
module ed_calculator
  import GAM_package::*;
#(
  parameter int unsigned VECTOR_LEN = GAM_package::VECTOR_LEN,
  parameter int unsigned ELEM_W     = GAM_package::ELEM_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [VECTOR_LEN*ELEM_W-1:0] x,
  input  logic [VECTOR_LEN*ELEM_W-1:0] w,
  output logic                         out_valid,
  output logic [31:0]                  ED
);

  localparam int unsigned SqW       = 2 * ELEM_W;
  localparam int unsigned LvlN      = $clog2(VECTOR_LEN);
  localparam int unsigned SumW      = SqW + LvlN;
  // Tree is padded to a power of two; unused leaves are zero.
  localparam int unsigned NumLeaves = 1 << LvlN;
  localparam int unsigned NumNodes  = 2 * NumLeaves - 1;

  logic [SqW-1:0]  sq [VECTOR_LEN];
  logic [SumW-1:0] tree [NumNodes];
  logic            v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [SumW-1:0] sum_d, sum_q;

  for (genvar j = 0; j < VECTOR_LEN; j++) begin : g_elem
    ed_sq_diff #(
      .ELEM_W (ELEM_W)
    ) u_sq_diff (
      .clk_i     (clk),
      .rst_i     (rst),
      .ld_diff_i (in_valid),
      .ld_sq_i   (v1_q),
      .x_e_i     (x[j*ELEM_W +: ELEM_W]),
      .w_e_i     (w[j*ELEM_W +: ELEM_W]),
      .sq_o      (sq[j])
    );
  end

  // Balanced adder tree in heap order: root at 0, children of i at 2i+1 and 2i+2.
  always_comb begin
    for (int i = 0; i < int'(NumNodes); i++) begin
      tree[i] = '0;
    end
    for (int j = 0; j < int'(VECTOR_LEN); j++) begin
      tree[int'(NumLeaves) - 1 + j] = SumW'(sq[j]);
    end
    for (int i = int'(NumLeaves) - 2; i >= 0; i--) begin
      tree[i] = tree[2*i+1] + tree[2*i+2];
    end
    sum_d = v2_q ? tree[0] : sum_q;
  end

  // Valid bits travel alongside the data through each stage.
  always_comb begin
    v1_d = in_valid;
    v2_d = v1_q;
    v3_d = v2_q;
  end

  // Valid and sum registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      sum_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      sum_q <= sum_d;
    end
  end

`ifdef ED_SQRT_EN
  localparam int unsigned RootW = (SumW + 1) / 2;
  localparam int unsigned RemW  = 2 * RootW + 3;

  // Non-restoring integer square root, two radicand bits per iteration.
  function automatic logic [RootW-1:0] isqrt(input logic [SumW-1:0] d);
    logic [2*RootW-1:0] dp;
    logic [RemW-1:0]    r;
    logic [RootW-1:0]   q;
    logic [RemW-1:0]    pair;
    dp = (2*RootW)'(d);
    r  = '0;
    q  = '0;
    for (int i = int'(RootW) - 1; i >= 0; i--) begin
      pair = RemW'(dp[2*i +: 2]);
      if (!r[RemW-1]) begin
        r = (r << 2) + pair - RemW'({q, 2'b01});
      end else begin
        r = (r << 2) + pair + RemW'({q, 2'b11});
      end
      q = {q[RootW-2:0], ~r[RemW-1]};
    end
    return q;
  endfunction

  logic             v4_d, v4_q;
  logic [RootW-1:0] root_d, root_q;

  // Stage 4 next-state: root loads only behind a valid stage-3 result.
  always_comb begin
    v4_d   = v3_q;
    root_d = v3_q ? isqrt(sum_q) : root_q;
  end

  // Stage 4 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v4_q   <= 1'b0;
      root_q <= '0;
    end else begin
      v4_q   <= v4_d;
      root_q <= root_d;
    end
  end

  assign out_valid = v4_q;
  assign ED        = 32'(root_q);
`else
  assign out_valid = v3_q;
  assign ED        = 32'(sum_q);
`endif

endmodule

// File: tb/tb_ed_calculator.sv
// Scoreboard bench for ed_calculator: stimulus pushes expected results, a monitor pops them.
module tb_ed_calculator;
  import GAM_package::*;

`ifdef ED_SQRT_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 3;
`endif

  typedef struct {
    logic [31:0] ed;
    int          cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  node_vector_T x;
  node_vector_T w;
  logic         out_valid;
  logic [31:0]  ED;

  exp_t        sb_q[$];
  int          cyc;
  logic        rst_d;
  logic [31:0] hold;
  int          n_tests;
  int          n_fail;

  ed_calculator u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .ED        (ED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] sq, input logic [31:0] rt);
`ifdef ED_SQRT_EN
    return rt;
`else
    return sq;
`endif
  endfunction

  // Monitor: every output cycle is checked against the scoreboard or the held value.
  always @(negedge clk) begin
    exp_t e;
    if (rst_d === 1'b1) begin
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_ed", ED, 32'd0);
      hold = 32'd0;
    end else if (rst_d === 1'b0) begin
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result_cycle", 32'(cyc), 32'(e.cyc));
          chk("result_ed", ED, e.ed);
          hold = e.ed;
        end
      end else begin
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("ed_held", ED, hold);
      end
    end
  end

  task automatic send(input node_vector_T xv, input node_vector_T wv,
                      input logic [31:0] sq, input logic [31:0] rt, input bit expect_out);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x        = xv;
    w        = wv;
    if (expect_out) begin
      e.ed  = pick(sq, rt);
      e.cyc = cyc + Lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    node_vector_T x10, x5, wv, ones, zeros;
    x10   = 128'h000A0014_00A02800_0000DC28_5000148C;
    x5    = 128'h050F0519_05A52D05_0505E12D_55051991;
    wv    = 128'h0A140A1E_0AAA320A_0A0AE632_5A0A1E96;
    ones  = {16{8'hFF}};
    zeros = '0;

    cyc      = 0;
    n_tests  = 0;
    n_fail   = 0;
    hold     = 32'd0;
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = x10;
    w        = wv;

    // Reset held two cycles with in_valid asserted; nothing may emerge.
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(4);

    // Single vector, every element differs by 10.
    send(x10, wv, 32'd1600, 32'd40, 1'b1);
    idle(6);

    // Back-to-back: differences of 10 then 5.
    send(x10, wv, 32'd1600, 32'd40, 1'b1);
    send(x5, wv, 32'd400, 32'd20, 1'b1);
    idle(6);

    // Extremes, swap symmetry, then x == w.
    send(ones, zeros, 32'd1040400, 32'd1020, 1'b1);
    send(zeros, ones, 32'd1040400, 32'd1020, 1'b1);
    send(x10, x10, 32'd0, 32'd0, 1'b1);
    idle(6);

    // Bubble between two inputs; ED must hold across the gap.
    send(x5, wv, 32'd400, 32'd20, 1'b1);
    idle(1);
    send(x10, wv, 32'd1600, 32'd40, 1'b1);
    idle(6);

    // Reset one cycle after an input: that result must never appear.
    send(ones, zeros, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);

    // Recovery after reset.
    send(x5, wv, 32'd400, 32'd20, 1'b1);
    idle(1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    idle(2);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
